serial_word_deser: RTL
======================

// Module: serial_word_deser
// PURPOSE
//  Receiving end of the single-bit serial shift path. Collects a clock-enabled
//  bit stream, LSB first, into LN-bit words. The first bit received lands in
//  word bit 0, which is the same order the serial shift FIFO emits on o_bit.
//  Completed words go into a 2-entry output queue that the downstream consumer
//  drains with a valid/ready handshake.
// PARAMETERS
//  LN      8    word width in bits; LN >= 2
//  CNTW    $clog2(LN+1)   bit-counter width (derived; do not override)
// PORTS
//  i_clk      in   1    single clock; all logic on posedge
//  i_reset_n  in   1    asynchronous, active-low reset
//  i_ce       in   1    qualifies i_bit; exactly one bit is taken per cycle with i_ce=1
//  i_bit      in   1    serial data bit
//  i_sync     in   1    frame alignment: restart the word at bit 0
//  i_ready    in   1    consumer accepts o_word this cycle
//  o_valid    out  1    queue head is valid
//  o_word     out  LN   queue head word
//  o_perr     out  1    parity error flag of the head word (0 when feature absent)
//  o_overrun  out  1    one-cycle pulse: a completed word was dropped
// BEHAVIOUR
//  Reset (async assert, sync deassert by the system):
//   - shift reg = 0, bit count = 0, state = S_DATA, queue empty
//   - o_valid = 0, o_word = 0, o_perr = 0, o_overrun = 0
//  Shift:
//   - On i_ce: sreg <= {i_bit, sreg[LN-1:1]} and the bit count increments.
//   - The input side has no backpressure. Bits are never stalled.
//  FSM:
//   - S_DATA: the LN-th accepted bit completes the word.
//     - Without parity: push the word; the bit count returns to 0; stay in S_DATA.
//     - With parity: go to S_PAR.
//   - S_PAR: the next i_ce bit is the even-parity bit.
//     - Push {word, perr}, where perr = ^word ^ parity bit.
//     - Return to S_DATA with bit count 0.
//  i_sync:
//   - Synchronously discards the partial word and returns the FSM to S_DATA.
//   - If i_ce is high in the same cycle, that bit becomes bit 0 of the new word.
//   - i_sync never affects queued words.
//  Queue (2 entries, registered head):
//   - A completed word is visible on o_valid/o_word the cycle after its last
//     bit is accepted (latency 1).
//   - Pop occurs on o_valid & i_ready. o_word/o_perr hold stable while
//     o_valid=1 and i_ready=0.
//   - A push is accepted if the queue holds fewer than 2 entries, or if a pop
//     happens in the same cycle.
//   - Otherwise the new word is dropped, the queue is unchanged, and o_overrun=1
//     for exactly one cycle.
//   - Simultaneous push and pop with 1 entry: the second word becomes head next
//     cycle with no bubble.
//   - Empty: o_word holds its last value; consumers must ignore it when o_valid=0.
//  Reset mid-word or mid-queue:
//   - All state clears immediately. Partial and queued words are lost and no
//     overrun is flagged.
// CONFIGURATION
//  SERIAL_WORD_DESER_PARITY_EN
//   - Defined: S_PAR is present. A frame is LN+1 bits and o_perr carries the
//     parity result per word.
//   - Undefined: S_PAR and the per-entry perr storage are removed, a frame is
//     LN bits, and o_perr is tied 0.
// TESTING
//  1. LN=8, i_ce=1, bits 1,0,1,1,0,0,0,0, i_ready=1 -> o_valid=1 for one cycle
//     after the 8th bit, o_word=8'h0D.
//  2. Two back-to-back words 8'hA5, 8'h3C with i_ready=0 -> queue full,
//     o_word=8'hA5 held. A third word completes -> o_overrun=1 for one cycle.
//     Then with i_ready=1: pops 8'hA5, then 8'h3C, then o_valid=0.
//  3. Three bits sent, then i_sync=1 with i_ce=1 and i_bit=1, then 7 more bits
//     of 0 -> o_word=8'h01.
//  4. i_reset_n low while 1 word is queued and 4 bits are partial -> o_valid=0
//     at once. After release, a fresh 8 bits give a correct word.
//  5. i_ce with gaps (1 bit every 3 cycles) for word 8'hFF -> o_word=8'hFF
//     with no extra or missing bits.
//  6. PARITY_EN: word 8'h07 + parity 1 -> o_perr=0; word 8'h07 + parity 0 ->
//     o_perr=1. Each frame is 9 bits.

Source files
------------

// File: rtl/serial_word_deser.sv
// serial_word_deser: LSB-first serial-to-word deserializer with 2-entry output queue; parity via SERIAL_WORD_DESER_PARITY_EN
module serial_word_deser #(
    parameter int LN   = 8,
    parameter int CNTW = $clog2(LN + 1)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_ce,
    input  logic          i_bit,
    input  logic          i_sync,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [LN-1:0] o_word,
    output logic          o_perr,
    output logic          o_overrun
);
`ifdef SERIAL_WORD_DESER_PARITY_EN
    localparam int EW = LN + 1;
    typedef enum logic {S_DATA, S_PAR} state_t;
    state_t          state;
    logic [LN-1:0]   sreg;
`else
    localparam int EW = LN;
    logic [LN-2:0]   sreg;
`endif
    logic [CNTW-1:0] cnt;
    logic            push;
    logic [LN-1:0]   p_word;
    logic [EW-1:0]   p_ent;
    logic [EW-1:0]   h_ent;
    logic [EW-1:0]   t_ent;
    logic            t_valid;
    logic            pop;
    logic            accept;
    logic            last_bit;
    assign last_bit = cnt == CNTW'(LN - 1);
`ifdef SERIAL_WORD_DESER_PARITY_EN
    // the data word is complete in sreg by the time the parity bit arrives
    assign push   = i_ce & ~i_sync & (state == S_PAR);
    assign p_word = sreg;
    assign p_ent  = {^sreg ^ i_bit, sreg};
    assign o_perr = h_ent[LN];
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sreg  <= '0;
            cnt   <= '0;
            state <= S_DATA;
        end else if (i_sync) begin
            state <= S_DATA;
            cnt   <= CNTW'(i_ce);
            if (i_ce) sreg <= {i_bit, sreg[LN-1:1]};
        end else if (i_ce) begin
            if (state == S_PAR) begin
                state <= S_DATA;
                cnt   <= '0;
            end else begin
                sreg  <= {i_bit, sreg[LN-1:1]};
                cnt   <= last_bit ? '0 : cnt + CNTW'(1);
                state <= last_bit ? S_PAR : S_DATA;
            end
        end
    end
`else
    // the word completes on the same cycle as its last bit, so splice i_bit in directly
    assign push   = i_ce & ~i_sync & last_bit;
    assign p_word = {i_bit, sreg};
    assign p_ent  = p_word;
    assign o_perr = 1'b0;
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sreg <= '0;
            cnt  <= '0;
        end else begin
            if (i_ce) sreg <= p_word[LN-1:1];
            cnt <= i_sync ? CNTW'(i_ce) : i_ce ? (last_bit ? '0 : cnt + CNTW'(1)) : cnt;
        end
    end
`endif
    assign pop    = o_valid & i_ready;
    assign accept = push & (~(o_valid & t_valid) | pop);
    assign o_word = h_ent[LN-1:0];
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid   <= 1'b0;
            t_valid   <= 1'b0;
            h_ent     <= '0;
            t_ent     <= '0;
            o_overrun <= 1'b0;
        end else begin
            o_overrun <= push & ~accept;
            if (pop) begin
                if (t_valid) begin
                    h_ent   <= t_ent;
                    t_valid <= accept;
                    if (accept) t_ent <= p_ent;
                end else begin
                    o_valid <= accept;
                    if (accept) h_ent <= p_ent;
                end
            end else if (accept) begin
                if (o_valid) begin
                    t_valid <= 1'b1;
                    t_ent   <= p_ent;
                end else begin
                    o_valid <= 1'b1;
                    h_ent   <= p_ent;
                end
            end
        end
    end
endmodule
